// File: rtl/pc_fetch_seq_pkg.sv
// Shared types and constants for the PC fetch sequencer.
package pc_fetch_seq_pkg;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HOLD   = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_t;

  localparam logic [15:0] PC_STEP = 16'h0002;

  // Instructions are 16-bit aligned, so bit 0 of any PC is forced low.
  function automatic logic [15:0] even_pc(input logic [15:0] addr);
    return {addr[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/CLA_16bit.sv
// 16-bit carry-lookahead adder/subtractor built from 4-bit lookahead groups.
module CLA_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  input  logic        sub,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] bx;
  logic [15:0] g;
  logic [15:0] p;
  logic [16:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;

  always_comb begin
    bx = b ^ {16{sub}};
    g  = a & bx;
    p  = a ^ bx;
    gg = '0;
    gp = '0;
    c  = '0;
    // Subtraction is a + ~b + 1, so sub forces the carry-in.
    c[0] = cin | sub;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & (g[4*k+2] | (p[4*k+2] &
              (g[4*k+1] | (p[4*k+1] & g[4*k])))));
      gp[k] = &p[4*k +: 4];
      for (int i = 0; i < 3; i++) begin
        c[4*k+i+1] = g[4*k+i] | (p[4*k+i] & c[4*k+i]);
      end
      c[4*k+4] = gg[k] | (gp[k] & c[4*k]);
    end
    sum  = p ^ c[15:0];
    cout = c[16];
  end

endmodule

// File: rtl/pc_fetch_seq.sv
// Instruction fetch sequencer: walks the PC, handshakes with imem, and
// handles redirect, downstream stall and halt/resume.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_BOOT   | one idle cycle after reset, no request
// ST_FETCH  | imem_req high at pc, waiting for imem_ack
// ST_HOLD   | instruction acked but stalled downstream, held valid
// ST_HALTED | HLT executed, idle until resume
module pc_fetch_seq
  import pc_fetch_seq_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        stall,
  input  logic        halt,
  input  logic        resume,
  input  logic        imem_ack,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  output logic [15:0] pc,
  output logic        fetch_valid,
  output logic        flush,
  output logic        halted
);

  localparam logic [15:0] RESET_PC_EVEN = even_pc(RESET_PC);

  fetch_state_t state;
  logic [15:0]  pc_inc;
  logic         unused_carry;
  logic         active;

  CLA_16bit u_pc_inc (
    .a    (pc),
    .b    (PC_STEP),
    .cin  (1'b0),
    .sub  (1'b0),
    .sum  (pc_inc),
    .cout (unused_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_BOOT;
      pc    <= RESET_PC_EVEN;
    end else begin
      case (state)
        ST_BOOT: state <= ST_FETCH;
        ST_FETCH: begin
          if (halt) begin
            state <= ST_HALTED;
          end else if (redirect) begin
            pc <= even_pc(redirect_pc);
          end else if (imem_ack) begin
            if (stall) state <= ST_HOLD;
            else       pc    <= pc_inc;
          end
        end
        ST_HOLD: begin
          if (halt) begin
            state <= ST_HALTED;
          end else if (redirect) begin
            pc    <= even_pc(redirect_pc);
            state <= ST_FETCH;
          end else if (!stall) begin
            pc    <= pc_inc;
            state <= ST_FETCH;
          end
        end
        ST_HALTED: if (resume) state <= ST_FETCH;
      endcase
    end
  end

  // imem_req and halted decode only the state register; imem_ack never
  // reaches imem_req.  Halt and redirect both squash the current fetch.
  assign active      = (state == ST_FETCH) || (state == ST_HOLD);
  assign imem_req    = (state == ST_FETCH);
  assign halted      = (state == ST_HALTED);
  assign imem_addr   = pc;
  assign flush       = active && redirect && !halt;
  assign fetch_valid = !halt && !redirect &&
                       (((state == ST_FETCH) && imem_ack) || (state == ST_HOLD));

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Directed self-checking bench for pc_fetch_seq.
module tb_pc_fetch_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        stall;
  logic        halt;
  logic        resume;
  logic        imem_ack;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] pc;
  logic        fetch_valid;
  logic        flush;
  logic        halted;

  int checks = 0;
  int errors = 0;

  pc_fetch_seq #(.RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .halt        (halt),
    .resume      (resume),
    .imem_ack    (imem_ack),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .pc          (pc),
    .fetch_valid (fetch_valid),
    .flush       (flush),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_out(input string tag, input logic req, input logic [15:0] exp_pc,
                         input logic vld, input logic fl, input logic hl);
    chk({tag, "_req"},   {15'd0, imem_req},    {15'd0, req});
    chk({tag, "_pc"},    pc,                   exp_pc);
    chk({tag, "_addr"},  imem_addr,            exp_pc);
    chk({tag, "_valid"}, {15'd0, fetch_valid}, {15'd0, vld});
    chk({tag, "_flush"}, {15'd0, flush},       {15'd0, fl});
    chk({tag, "_halted"},{15'd0, halted},      {15'd0, hl});
  endtask

  initial begin
    rst_n = 1'b0; redirect = 1'b1; redirect_pc = 16'h1234;
    stall = 1'b0; halt = 1'b0; resume = 1'b0; imem_ack = 1'b1;
    #3;
    chk_out("reset", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    redirect = 1'b0;
    #9;
    rst_n = 1'b1;
    settle();
    chk_out("boot", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

    // Back-to-back fetches with immediate ack.
    next_cycle(); settle(); chk_out("seq0", 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
    next_cycle(); settle(); chk_out("seq1", 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);
    next_cycle(); settle(); chk_out("seq2", 1'b1, 16'h0004, 1'b1, 1'b0, 1'b0);

    // Redirect to 0010 wins over a same-cycle ack.
    redirect = 1'b1; redirect_pc = 16'h0010;
    settle(); chk_out("rd10", 1'b1, 16'h0004, 1'b0, 1'b1, 1'b0);

    // Ack delayed three cycles.
    next_cycle(); redirect = 1'b0; imem_ack = 1'b0;
    settle(); chk_out("wait0", 1'b1, 16'h0010, 1'b0, 1'b0, 1'b0);
    next_cycle(); settle(); chk_out("wait1", 1'b1, 16'h0010, 1'b0, 1'b0, 1'b0);
    next_cycle(); settle(); chk_out("wait2", 1'b1, 16'h0010, 1'b0, 1'b0, 1'b0);
    next_cycle(); imem_ack = 1'b1;
    settle(); chk_out("wack", 1'b1, 16'h0010, 1'b1, 1'b0, 1'b0);

    // Odd redirect target with same-cycle ack.
    next_cycle(); redirect = 1'b1; redirect_pc = 16'h0041;
    settle(); chk_out("rd41", 1'b1, 16'h0012, 1'b0, 1'b1, 1'b0);
    next_cycle(); redirect = 1'b1; redirect_pc = 16'h0100; imem_ack = 1'b0;
    settle(); chk_out("at40", 1'b1, 16'h0040, 1'b0, 1'b1, 1'b0);

    // Ack under stall: HOLD for the stalled cycles.
    next_cycle(); redirect = 1'b0; imem_ack = 1'b1; stall = 1'b1;
    settle(); chk_out("stack", 1'b1, 16'h0100, 1'b1, 1'b0, 1'b0);
    next_cycle(); imem_ack = 1'b0;
    settle(); chk_out("hold1", 1'b0, 16'h0100, 1'b1, 1'b0, 1'b0);
    next_cycle(); stall = 1'b0;
    settle(); chk_out("hold2", 1'b0, 16'h0100, 1'b1, 1'b0, 1'b0);
    next_cycle(); redirect = 1'b1; redirect_pc = 16'h0020;
    settle(); chk_out("aft_hold", 1'b1, 16'h0102, 1'b0, 1'b1, 1'b0);

    // Halt beats redirect; HALTED ignores redirect and stall.
    next_cycle(); halt = 1'b1; redirect = 1'b1; redirect_pc = 16'h0080;
    settle(); chk_out("halt", 1'b1, 16'h0020, 1'b0, 1'b0, 1'b0);
    next_cycle(); halt = 1'b0; stall = 1'b1;
    settle(); chk_out("halted0", 1'b0, 16'h0020, 1'b0, 1'b0, 1'b1);
    next_cycle(); redirect = 1'b0; stall = 1'b0; resume = 1'b1;
    settle(); chk_out("halted1", 1'b0, 16'h0020, 1'b0, 1'b0, 1'b1);
    next_cycle(); resume = 1'b0; redirect = 1'b1; redirect_pc = 16'hFFFF;
    settle(); chk_out("resumed", 1'b1, 16'h0020, 1'b0, 1'b1, 1'b0);

    // PC wrap at FFFE.
    next_cycle(); redirect = 1'b0; imem_ack = 1'b1;
    settle(); chk_out("wrapff", 1'b1, 16'hFFFE, 1'b1, 1'b0, 1'b0);
    next_cycle(); settle(); chk_out("wrap0", 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
    next_cycle(); imem_ack = 1'b0;
    settle(); chk_out("midwait", 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);

    // Reset mid-wait drops the request immediately.
    #2 rst_n = 1'b0;
    settle(); chk_out("rstmid", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    next_cycle(); rst_n = 1'b1;
    settle(); chk_out("reboot", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    next_cycle(); settle(); chk_out("refetch", 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
